// File: rtl/max_heap_pkg.sv
// Shared constants, op codes and sizing helper for the max_heap priority queue.
package max_heap_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  typedef enum logic [1:0] {OP_HOLD, OP_INS, OP_DEL, OP_REP} op_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/max_heap_if.sv
// Command/status bundle between a heap client (master) and the heap (slave).
interface max_heap_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  insert;
  logic                  delete;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  heap_full;
  logic                  heap_empty;

  modport master (output data_in, insert, delete, input data_out, heap_full, heap_empty);
  modport slave  (input data_in, insert, delete, output data_out, heap_full, heap_empty);
endinterface

// File: rtl/max_heap_cell.sv
// One slot of the sorted shift array: holds, shifts from a neighbour, or captures data_in.
module max_heap_cell
  import max_heap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit FIRST      = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  op_e                   op,
  input  logic                  own_valid,
  input  logic [DATA_WIDTH-1:0] left,
  input  logic [DATA_WIDTH-1:0] right,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  lt_left,
  input  logic                  lt_right,
  output logic                  lt_own,
  output logic [DATA_WIDTH-1:0] value
);
  // Empty slots always count as "data_in goes here-or-left", keeping the flag vector monotonic.
  assign lt_own = !own_valid || (value < data_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else begin
      case (op)
        OP_INS: begin
          if (lt_left)     value <= left;
          else if (lt_own) value <= data_in;
        end
        OP_DEL: value <= right;
        // Slot 0 is being discarded, so it never keeps its own value on replace.
        OP_REP: begin
          if (!lt_right)             value <= right;
          else if (lt_own && !FIRST) value <= value;
          else                       value <= data_in;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/max_heap.sv
// Max-priority queue: DEPTH slots kept sorted descending, single-cycle insert/delete/replace.
module max_heap
  import max_heap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  max_heap_if.slave   bus
);
  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]                    count;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] slot;
  logic [DEPTH-1:0]                 lt;
  logic                             full, empty;
  op_e                              op;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Insert+delete on an empty heap degrades to a plain insert.
  always_comb begin
    op = OP_HOLD;
    if (bus.insert && bus.delete && !empty) op = OP_REP;
    else if (bus.insert && !full)           op = OP_INS;
    else if (bus.delete && !bus.insert && !empty) op = OP_DEL;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [DATA_WIDTH-1:0] left_v, right_v;
    logic                  left_lt, right_lt;

    if (i == 0) begin : g_lo
      assign left_v  = '0;
      assign left_lt = 1'b0;
    end else begin : g_lo
      assign left_v  = slot[i-1];
      assign left_lt = lt[i-1];
    end

    if (i == DEPTH - 1) begin : g_hi
      assign right_v  = '0;
      assign right_lt = 1'b1;
    end else begin : g_hi
      assign right_v  = slot[i+1];
      assign right_lt = lt[i+1];
    end

    max_heap_cell #(.DATA_WIDTH(DATA_WIDTH), .FIRST(i == 0)) u_cell (
      .clk       (clk),
      .reset     (reset),
      .op        (op),
      .own_valid (CW'(i) < count),
      .left      (left_v),
      .right     (right_v),
      .data_in   (bus.data_in),
      .lt_left   (left_lt),
      .lt_right  (right_lt),
      .lt_own    (lt[i]),
      .value     (slot[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case (op)
        OP_INS:  count <= count + 1'b1;
        OP_DEL:  count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.data_out   = slot[0];
  assign bus.heap_full  = full;
  assign bus.heap_empty = empty;
endmodule

// File: tb/tb_max_heap.sv
// Self-checking bench for max_heap: sorted-queue reference model feeding an expectation scoreboard.
module tb_max_heap;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  max_heap_if #(.DATA_WIDTH(DW)) bus ();

  max_heap #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    int    dout;
    bit    full;
    bit    empty;
  } exp_t;

  exp_t exp_q[$];
  int   model[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain descending queue, new key placed after equal keys.
  task automatic model_ins(input int d);
    int p;
    p = model.size();
    for (int k = 0; k < model.size(); k++)
      if (model[k] < d) begin p = k; break; end
    model.insert(p, d);
  endtask

  task automatic cmd(input string tag, input bit rst, input bit ins, input bit del, input int d);
    exp_t e;
    @(negedge clk);
    reset       = rst;
    bus.insert  = ins;
    bus.delete  = del;
    bus.data_in = DW'(d);
    if (rst) model.delete();
    else if (ins && del && model.size() > 0) begin
      void'(model.pop_front());
      model_ins(d);
    end else if (ins && model.size() < DEPTH) model_ins(d);
    else if (del && !ins && model.size() > 0) void'(model.pop_front());
    e.tag   = tag;
    e.dout  = (model.size() > 0) ? model[0] : 0;
    e.full  = (model.size() == DEPTH);
    e.empty = (model.size() == 0);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".dout"},  32'(bus.data_out),   32'(e.dout));
    check({e.tag, ".full"},  32'(bus.heap_full),  32'(e.full));
    check({e.tag, ".empty"}, 32'(bus.heap_empty), 32'(e.empty));
  endtask

  task automatic idle(input string tag);
    cmd(tag, 1'b0, 1'b0, 1'b0, 0);
  endtask

  int ins_keys[6] = '{10, 20, 5, 7, 25, 3};

  initial begin
    reset = 1'b1; bus.insert = 1'b0; bus.delete = 1'b0; bus.data_in = '0;
    cmd("rst", 1'b1, 1'b0, 1'b0, 0);
    idle("idle0");
    cmd("del_empty", 1'b0, 1'b0, 1'b1, 0);

    foreach (ins_keys[k]) begin
      cmd($sformatf("ins%0d", ins_keys[k]), 1'b0, 1'b1, 1'b0, ins_keys[k]);
      idle("gap");
    end
    for (int k = 0; k < 3; k++) cmd("del_a", 1'b0, 1'b0, 1'b1, 0);
    cmd("ins15", 1'b0, 1'b1, 1'b0, 15);
    cmd("ins17", 1'b0, 1'b1, 1'b0, 17);
    for (int k = 0; k < 5; k++) cmd("del_b", 1'b0, 1'b0, 1'b1, 0);
    cmd("del_empty2", 1'b0, 1'b0, 1'b1, 0);

    for (int k = 1; k <= DEPTH; k++) cmd("fill", 1'b0, 1'b1, 1'b0, k);
    cmd("ins_full", 1'b0, 1'b1, 1'b0, 200);
    cmd("rep_full", 1'b0, 1'b1, 1'b1, 200);
    cmd("rep_low",  1'b0, 1'b1, 1'b1, 0);

    cmd("rst2", 1'b1, 1'b0, 1'b0, 0);
    cmd("b2b_i9a", 1'b0, 1'b1, 1'b0, 9);
    cmd("b2b_i9b", 1'b0, 1'b1, 1'b0, 9);
    cmd("b2b_d1",  1'b0, 1'b0, 1'b1, 0);
    cmd("b2b_d2",  1'b0, 1'b0, 1'b1, 0);
    cmd("rep_empty", 1'b0, 1'b1, 1'b1, 42);

    cmd("pre_a", 1'b0, 1'b1, 1'b0, 4);
    cmd("pre_b", 1'b0, 1'b1, 1'b0, 30);
    cmd("pre_c", 1'b0, 1'b1, 1'b0, 12);
    cmd("rst_ins", 1'b1, 1'b1, 1'b0, 99);
    idle("post_rst");

    for (int k = 0; k < 300; k++) begin
      int r;
      r = $urandom_range(0, 9);
      cmd("rand", 1'b0, r < 5, (r >= 4) && (r < 8), $urandom_range(0, 255));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
